// File: rtl/tff.sv
// Parameterised toggle flip-flop register with registered toggle flags.
// Define TFF_TOGGLE_CNT_EN to add a saturating count of bit-0 flips on toggle_cnt.
module tff #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  parameter int unsigned           CNT_W     = 8
) (
  input  logic [WIDTH-1:0] t,
  input  logic             rst,
  input  logic             clk,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
`ifdef TFF_TOGGLE_CNT_EN
  output logic [WIDTH-1:0] toggled,
  output logic [CNT_W-1:0] toggle_cnt
`else
  output logic [WIDTH-1:0] toggled
`endif
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] toggled_q, toggled_d;

  always_comb begin
    q_d       = q_q ^ t;
    toggled_d = t;
  end

  // Reset wins over any toggle request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= RESET_VAL;
      toggled_q <= '0;
    end else begin
      q_q       <= q_d;
      toggled_q <= toggled_d;
    end
  end

  assign q       = q_q;
  assign qn      = ~q_q;
  assign toggled = toggled_q;

`ifdef TFF_TOGGLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at all-ones rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (t[0] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign toggle_cnt = cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_tff.sv
// Directed bench for tff: a 1-bit instance and a 4-bit instance with non-zero reset value.
// The counter checks are built only when TFF_TOGGLE_CNT_EN is defined.
module tb_tff;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] t1;
  logic [0:0] q1, qn1, tog1;
  logic [3:0] t4, q4, qn4, tog4;
`ifdef TFF_TOGGLE_CNT_EN
  logic [2:0] cnt1;
  logic [7:0] cnt4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tff #(
    .WIDTH    (1),
    .RESET_VAL(1'b0),
    .CNT_W    (3)
  ) u_dut1 (
    .t         (t1),
    .rst       (rst),
    .clk       (clk),
    .q         (q1),
    .qn        (qn1),
`ifdef TFF_TOGGLE_CNT_EN
    .toggled   (tog1),
    .toggle_cnt(cnt1)
`else
    .toggled   (tog1)
`endif
  );

  tff #(
    .WIDTH    (4),
    .RESET_VAL(4'b0011)
  ) u_dut4 (
    .t         (t4),
    .rst       (rst),
    .clk       (clk),
    .q         (q4),
    .qn        (qn4),
`ifdef TFF_TOGGLE_CNT_EN
    .toggled   (tog4),
    .toggle_cnt(cnt4)
`else
    .toggled   (tog4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic exp_q, input logic exp_tog);
    chk({tag, ".q"}, {31'd0, q1}, {31'd0, exp_q});
    chk({tag, ".qn"}, {31'd0, qn1}, {31'd0, ~exp_q});
    chk({tag, ".tog"}, {31'd0, tog1}, {31'd0, exp_tog});
  endtask

  initial begin
    logic [3:0] exp_seq;
    rst = 1'b1;
    t1  = 1'b1;
    t4  = 4'b1111;
    #2;

    // Reset with toggle requested: reset wins.
    for (int i = 0; i < 2; i++) begin
      step();
      chk1("reset", 1'b0, 1'b0);
      chk("reset.q4", {28'd0, q4}, 32'h3);
      chk("reset.qn4", {28'd0, qn4}, 32'hc);
      chk("reset.tog4", {28'd0, tog4}, 32'h0);
    end

    // Hold.
    rst = 1'b0;
    t1  = 1'b0;
    t4  = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("hold", 1'b0, 1'b0);
      chk("hold.q4", {28'd0, q4}, 32'h3);
    end

    // Toggle: q1 = 1,0,1,0; meanwhile multi-bit vectors on the 4-bit instance.
    t1      = 1'b1;
    t4      = 4'b0101;
    exp_seq = 4'b0101;
    step();
    chk1("toggle0", exp_seq[0], 1'b1);
    chk("mb.q4_a", {28'd0, q4}, 32'h6);
    chk("mb.tog4_a", {28'd0, tog4}, 32'h5);
    t4 = 4'b1111;
    step();
    chk1("toggle1", exp_seq[1], 1'b1);
    chk("mb.q4_b", {28'd0, q4}, 32'h9);
    chk("mb.qn4_b", {28'd0, qn4}, 32'h6);
    chk("mb.tog4_b", {28'd0, tog4}, 32'hf);
    t4 = 4'b0000;
    step();
    chk1("toggle2", exp_seq[2], 1'b1);
    chk("mb.q4_c", {28'd0, q4}, 32'h9);
    chk("mb.tog4_c", {28'd0, tog4}, 32'h0);
    step();
    chk1("toggle3", exp_seq[3], 1'b1);

    // Reset priority mid-operation.
    step();
    chk1("pre_rst", 1'b1, 1'b1);
    rst = 1'b1;
    step();
    chk1("mid_rst", 1'b0, 1'b0);
    chk("mid_rst.q4", {28'd0, q4}, 32'h3);
    rst = 1'b0;
    step();
    chk1("rst_release", 1'b1, 1'b1);

`ifdef TFF_TOGGLE_CNT_EN
    rst = 1'b1;
    step();
    chk("cnt.reset", {29'd0, cnt1}, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("cnt.run", {29'd0, cnt1}, (i > 7) ? 32'd7 : i);
    end
    t1 = 1'b0;
    step();
    chk("cnt.hold", {29'd0, cnt1}, 32'd7);
    rst = 1'b1;
    step();
    chk("cnt.clear", {29'd0, cnt1}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
